// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: RV32I major-opcode constants, sequencer FSM state type and
// the opcode classification helpers shared by the classifier and hazard logic.
package alu_seq_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  function automatic logic is_legal(input logic [6:0] opcode);
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JALR, OP_LUI, OP_AUIPC, OP_JAL: is_legal = 1'b1;
      default:                           is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic writes_rd(input logic [6:0] opcode);
    case (opcode)
      OP_R, OP_I, OP_JALR, OP_LUI, OP_AUIPC, OP_JAL: writes_rd = 1'b1;
      default:                                       writes_rd = 1'b0;
    endcase
  endfunction

  // U/J formats carry no source registers, so their index fields are don't-care.
  function automatic logic uses_rs(input logic [6:0] opcode);
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL: uses_rs = 1'b0;
      default:                  uses_rs = is_legal(opcode);
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_classify.sv
// alu_seq_classify: combinational opcode decoder producing the legal,
// writes-rd and uses-source-registers flags.
module alu_seq_classify
  import alu_seq_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic       o_legal,
  output logic       o_writes_rd,
  output logic       o_uses_rs
);

  assign o_legal     = is_legal(i_opcode);
  assign o_writes_rd = writes_rd(i_opcode);
  assign o_uses_rs   = uses_rs(i_opcode);

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: IDLE->READ->EXEC->WB execute controller feeding the ALU datapath.
// Optional macro ALU_SEQ_PERF_EN adds retired-instruction and stall counters.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int EXEC_CYCLES = 1,
  parameter int XLEN        = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            iVALID,
  output logic            oREADY,
  input  logic [6:0]      iOPCODE,
  input  logic [4:0]      iRD,
  input  logic [4:0]      iRS1,
  input  logic [4:0]      iRS2,
  output logic [4:0]      oRF_RS1,
  output logic [4:0]      oRF_RS2,
  input  logic [XLEN-1:0] iRF_DATA1,
  input  logic [XLEN-1:0] iRF_DATA2,
  output logic [6:0]      oALU_OPCODE,
  output logic [XLEN-1:0] oALU_IN1,
  output logic [XLEN-1:0] oALU_IN2,
  input  logic [XLEN-1:0] iALU_OUT,
  output logic            oWB_EN,
  output logic [4:0]      oWB_RD,
  output logic [XLEN-1:0] oWB_DATA,
  output logic            oRESULT_VALID,
  output logic [XLEN-1:0] oRESULT,
  output logic            oILLEGAL,
  output logic            oBUSY
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [31:0]     oPERF_RETIRED,
  output logic [31:0]     oPERF_STALL
`endif
);

  if (EXEC_CYCLES < 1) begin : g_exec_cycles_check
    $error("alu_sequencer: EXEC_CYCLES must be >= 1");
  end

  localparam int CW = $clog2(EXEC_CYCLES + 1);
  localparam logic [CW-1:0] LP_CNT_LOAD = CW'(EXEC_CYCLES);
  localparam logic [CW-1:0] LP_CNT_ONE  = CW'(1);

  state_e            r_state;
  state_e            w_next_state;
  logic              w_ready;
  logic              w_accept;
  logic              w_legal;
  logic              w_writes_rd;
  logic              w_uses_rs;
  logic [6:0]        r_opcode;
  logic [4:0]        r_rd;
  logic              r_writes_rd;
  logic [CW-1:0]     r_cnt;
  logic [4:0]        r_rf_rs1;
  logic [4:0]        r_rf_rs2;
  logic [6:0]        r_alu_opcode;
  logic [XLEN-1:0]   r_alu_in1;
  logic [XLEN-1:0]   r_alu_in2;
  logic              r_wb_en;
  logic [4:0]        r_wb_rd;
  logic [XLEN-1:0]   r_wb_data;
  logic              r_result_valid;
  logic [XLEN-1:0]   r_result;
  logic              r_illegal;

  alu_seq_classify u_classify (
    .i_opcode    (iOPCODE),
    .o_legal     (w_legal),
    .o_writes_rd (w_writes_rd),
    .o_uses_rs   (w_uses_rs)
  );

  assign w_ready  = (r_state == ST_IDLE);
  assign w_accept = iVALID && w_ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_legal) w_next_state = ST_READ;
        else                     w_next_state = ST_IDLE;
      end
      ST_READ: w_next_state = ST_EXEC;
      ST_EXEC: begin
        if (r_cnt == LP_CNT_ONE) w_next_state = ST_WB;
        else                     w_next_state = ST_EXEC;
      end
      ST_WB:   w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Result/write-back fields are single-cycle pulses; ALU routing is zero outside EXEC.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_opcode       <= 7'd0;
      r_rd           <= 5'd0;
      r_writes_rd    <= 1'b0;
      r_cnt          <= '0;
      r_rf_rs1       <= 5'd0;
      r_rf_rs2       <= 5'd0;
      r_alu_opcode   <= 7'd0;
      r_alu_in1      <= '0;
      r_alu_in2      <= '0;
      r_wb_en        <= 1'b0;
      r_wb_rd        <= 5'd0;
      r_wb_data      <= '0;
      r_result_valid <= 1'b0;
      r_result       <= '0;
      r_illegal      <= 1'b0;
    end else begin
      r_illegal      <= w_accept && !w_legal;
      r_wb_en        <= 1'b0;
      r_wb_rd        <= 5'd0;
      r_wb_data      <= '0;
      r_result_valid <= 1'b0;
      r_result       <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_legal) begin
            r_opcode    <= iOPCODE;
            r_rd        <= iRD;
            r_writes_rd <= w_writes_rd;
            r_rf_rs1    <= w_uses_rs ? iRS1 : 5'd0;
            r_rf_rs2    <= w_uses_rs ? iRS2 : 5'd0;
          end
        end
        ST_READ: begin
          r_alu_opcode <= r_opcode;
          r_alu_in1    <= iRF_DATA1;
          r_alu_in2    <= iRF_DATA2;
          r_cnt        <= LP_CNT_LOAD;
          r_rf_rs1     <= 5'd0;
          r_rf_rs2     <= 5'd0;
        end
        ST_EXEC: begin
          if (r_cnt == LP_CNT_ONE) begin
            r_cnt          <= '0;
            r_alu_opcode   <= 7'd0;
            r_alu_in1      <= '0;
            r_alu_in2      <= '0;
            r_result_valid <= 1'b1;
            r_result       <= iALU_OUT;
            r_wb_en        <= r_writes_rd && (r_rd != 5'd0);
            r_wb_rd        <= r_rd;
            r_wb_data      <= iALU_OUT;
          end else begin
            r_cnt <= r_cnt - LP_CNT_ONE;
          end
        end
        ST_WB: begin
          r_cnt <= '0;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign oREADY        = w_ready;
  assign oBUSY         = !w_ready;
  assign oRF_RS1       = r_rf_rs1;
  assign oRF_RS2       = r_rf_rs2;
  assign oALU_OPCODE   = r_alu_opcode;
  assign oALU_IN1      = r_alu_in1;
  assign oALU_IN2      = r_alu_in2;
  assign oWB_EN        = r_wb_en;
  assign oWB_RD        = r_wb_rd;
  assign oWB_DATA      = r_wb_data;
  assign oRESULT_VALID = r_result_valid;
  assign oRESULT       = r_result;
  assign oILLEGAL      = r_illegal;

`ifdef ALU_SEQ_PERF_EN
  logic [31:0] r_perf_retired;
  logic [31:0] r_perf_stall;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_perf_retired <= 32'd0;
      r_perf_stall   <= 32'd0;
    end else begin
      if (r_result_valid) r_perf_retired <= r_perf_retired + 32'd1;
      else                r_perf_retired <= r_perf_retired;
      if (iVALID && !w_ready) r_perf_stall <= r_perf_stall + 32'd1;
      else                    r_perf_stall <= r_perf_stall;
    end
  end

  assign oPERF_RETIRED = r_perf_retired;
  assign oPERF_STALL   = r_perf_stall;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: drives two sequencers (EXEC_CYCLES=1 and 4) with table and
// random instructions against a cycle-timeline reference model.
module tb_alu_sequencer;

  typedef struct packed {
    logic        ready;
    logic        busy;
    logic        illegal;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  aop;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        rv;
    logic [31:0] res;
  } obs_t;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        exp_legal;
    logic        exp_wb_en;
    logic [31:0] exp_result;
  } rec_t;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [6:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] rf_mem [32];
  int          n_tests;
  int          n_fail;

  logic        rdy1, busy1, ill1, wben1, rv1;
  logic [4:0]  ra1_1, ra2_1, wbrd1;
  logic [6:0]  aop1;
  logic [31:0] rfd1_1, rfd2_1, in1_1, in2_1, alu1, wbd1, res1;
  logic        rdy4, busy4, ill4, wben4, rv4;
  logic [4:0]  ra1_4, ra2_4, wbrd4;
  logic [6:0]  aop4;
  logic [31:0] rfd1_4, rfd2_4, in1_4, in2_4, alu4, wbd4, res4;
`ifdef ALU_SEQ_PERF_EN
  logic [31:0] perf_ret1, perf_stall1, perf_ret4, perf_stall4;
`endif
  obs_t ob1, ob4;

  // Behavioural ALU: adds for address/arith classes, subtracts for branches,
  // operand-free constant for LUI/JAL so operand leakage would be visible.
  function automatic logic [31:0] alu_model(input logic [6:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o == 7'b1100011) return a - b;
    if (o == 7'b0110111 || o == 7'b1101111) return 32'hABCD_0000 ^ {25'd0, o};
    return a + b;
  endfunction

  assign rfd1_1 = rf_mem[ra1_1];
  assign rfd2_1 = rf_mem[ra2_1];
  assign rfd1_4 = rf_mem[ra1_4];
  assign rfd2_4 = rf_mem[ra2_4];
  assign alu1   = alu_model(aop1, in1_1, in2_1);
  assign alu4   = alu_model(aop4, in1_4, in2_4);

  alu_sequencer #(.EXEC_CYCLES(1), .XLEN(32)) u_dut1 (
    .CLK(clk), .RST(rst), .iVALID(valid), .oREADY(rdy1), .iOPCODE(op),
    .iRD(rd), .iRS1(rs1), .iRS2(rs2), .oRF_RS1(ra1_1), .oRF_RS2(ra2_1),
    .iRF_DATA1(rfd1_1), .iRF_DATA2(rfd2_1), .oALU_OPCODE(aop1),
    .oALU_IN1(in1_1), .oALU_IN2(in2_1), .iALU_OUT(alu1), .oWB_EN(wben1),
    .oWB_RD(wbrd1), .oWB_DATA(wbd1), .oRESULT_VALID(rv1), .oRESULT(res1),
    .oILLEGAL(ill1), .oBUSY(busy1)
`ifdef ALU_SEQ_PERF_EN
    , .oPERF_RETIRED(perf_ret1), .oPERF_STALL(perf_stall1)
`endif
  );

  alu_sequencer #(.EXEC_CYCLES(4), .XLEN(32)) u_dut4 (
    .CLK(clk), .RST(rst), .iVALID(valid), .oREADY(rdy4), .iOPCODE(op),
    .iRD(rd), .iRS1(rs1), .iRS2(rs2), .oRF_RS1(ra1_4), .oRF_RS2(ra2_4),
    .iRF_DATA1(rfd1_4), .iRF_DATA2(rfd2_4), .oALU_OPCODE(aop4),
    .oALU_IN1(in1_4), .oALU_IN2(in2_4), .iALU_OUT(alu4), .oWB_EN(wben4),
    .oWB_RD(wbrd4), .oWB_DATA(wbd4), .oRESULT_VALID(rv4), .oRESULT(res4),
    .oILLEGAL(ill4), .oBUSY(busy4)
`ifdef ALU_SEQ_PERF_EN
    , .oPERF_RETIRED(perf_ret4), .oPERF_STALL(perf_stall4)
`endif
  );

  always_comb begin
    ob1 = '{rdy1, busy1, ill1, ra1_1, ra2_1, aop1, in1_1, in2_1, wben1, wbrd1, wbd1, rv1, res1};
    ob4 = '{rdy4, busy4, ill4, ra1_4, ra2_4, aop4, in1_4, in2_4, wben4, wbrd4, wbd4, rv4, res4};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs k cycles after the handshake for a DUT with e execute cycles.
  function automatic obs_t exp_obs(input rec_t r, input int e, input int k);
    obs_t x;
    logic no_rs;
    logic [4:0] a1, a2;
    x = '0;
    x.ready = 1'b1;
    no_rs = (r.op == 7'b0110111) || (r.op == 7'b0010111) || (r.op == 7'b1101111);
    a1 = no_rs ? 5'd0 : r.rs1;
    a2 = no_rs ? 5'd0 : r.rs2;
    if (!r.exp_legal) begin
      x.illegal = (k == 1);
    end else if (k == 1) begin
      x.ready = 1'b0; x.busy = 1'b1; x.rs1 = a1; x.rs2 = a2;
    end else if (k <= e + 1) begin
      x.ready = 1'b0; x.busy = 1'b1; x.aop = r.op; x.in1 = rf_mem[a1]; x.in2 = rf_mem[a2];
    end else if (k == e + 2) begin
      x.ready = 1'b0; x.busy = 1'b1; x.rv = 1'b1; x.res = r.exp_result;
      x.wb_en = r.exp_wb_en;
      if (r.exp_wb_en) begin
        x.wb_rd = r.rd; x.wb_data = r.exp_result;
      end
    end
    return x;
  endfunction

  function automatic rec_t model_rec(input logic [6:0] o, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    rec_t r;
    logic no_rs;
    no_rs = (o == 7'b0110111) || (o == 7'b0010111) || (o == 7'b1101111);
    r.op = o; r.rd = d; r.rs1 = s1; r.rs2 = s2;
    r.exp_legal = o inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                            7'b1100111, 7'b0110111, 7'b0010111, 7'b1101111};
    r.exp_wb_en = (o inside {7'b0110011, 7'b0010011, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1101111})
                  && (d != 5'd0);
    r.exp_result = alu_model(o, rf_mem[no_rs ? 5'd0 : s1], rf_mem[no_rs ? 5'd0 : s2]);
    return r;
  endfunction

  task automatic check_obs(input string name, input obs_t act, input obs_t exp, input bit read_cyc, input bit strict);
    obs_t a;
    a = act;
    if (!strict) begin
      if (!exp.wb_en) begin a.wb_rd = '0; a.wb_data = '0; end
      if (!exp.rv) a.res = '0;
      if (!read_cyc) begin a.rs1 = '0; a.rs2 = '0; end
    end
    n_tests++;
    if (a !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, a, exp);
    end
  endtask

  task automatic check_idle(input string name);
    rec_t none;
    none = model_rec(7'd0, 5'd0, 5'd0, 5'd0);
    check_obs({name, " E1"}, ob1, exp_obs(none, 1, 9), 1'b1, 1'b1);
    check_obs({name, " E4"}, ob4, exp_obs(none, 4, 9), 1'b1, 1'b1);
  endtask

  // Called at a negedge with both DUTs idle; returns at the negedge of cycle N+7.
  task automatic run_instr(input string tag, input rec_t r);
    valid = 1'b1; op = r.op; rd = r.rd; rs1 = r.rs1; rs2 = r.rs2;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      check_obs($sformatf("%s k%0d E1", tag, k), ob1, exp_obs(r, 1, k), (k == 1) && r.exp_legal, 1'b0);
      check_obs($sformatf("%s k%0d E4", tag, k), ob4, exp_obs(r, 4, k), (k == 1) && r.exp_legal, 1'b0);
      if (k < 7) @(negedge clk);
    end
  endtask

  rec_t tbl [12];
  logic [6:0] legal_ops [9];

  initial begin
    n_tests = 0; n_fail = 0;
    valid = 1'b0; op = 7'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
    rf_mem[0] = 32'd0; rf_mem[1] = 32'd3; rf_mem[2] = 32'd4; rf_mem[3] = 32'h100;
    rf_mem[4] = 32'h8000_0000; rf_mem[5] = 32'hFFFF_FFFF;
    legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                  7'b1100111, 7'b0110111, 7'b0010111, 7'b1101111};

    tbl[0]  = '{7'b0110011, 5'd5,  5'd1, 5'd2, 1'b1, 1'b1, 32'd7};
    tbl[1]  = '{7'b0100011, 5'd7,  5'd0, 5'd3, 1'b1, 1'b0, 32'h100};
    tbl[2]  = '{7'b1111111, 5'd4,  5'd1, 5'd2, 1'b0, 1'b0, 32'd0};
    tbl[3]  = '{7'b0110111, 5'd0,  5'd1, 5'd2, 1'b1, 1'b0, 32'hABCD_0037};
    tbl[4]  = '{7'b0010011, 5'd31, 5'd4, 5'd5, 1'b1, 1'b1, 32'h7FFF_FFFF};
    tbl[5]  = '{7'b1100011, 5'd9,  5'd2, 5'd1, 1'b1, 1'b0, 32'd1};
    tbl[6]  = '{7'b0000011, 5'd10, 5'd5, 5'd5, 1'b1, 1'b0, 32'hFFFF_FFFE};
    tbl[7]  = '{7'b1101111, 5'd1,  5'd3, 5'd4, 1'b1, 1'b1, 32'hABCD_006F};
    tbl[8]  = '{7'b0010111, 5'd2,  5'd5, 5'd5, 1'b1, 1'b1, 32'd0};
    tbl[9]  = '{7'b1100111, 5'd3,  5'd3, 5'd1, 1'b1, 1'b1, 32'h103};
    tbl[10] = '{7'b0110011, 5'd0,  5'd1, 5'd1, 1'b1, 1'b0, 32'd6};
    tbl[11] = '{7'b0000000, 5'd6,  5'd2, 5'd3, 1'b0, 1'b0, 32'd0};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle("post-reset");

    for (int i = 0; i < 12; i++) run_instr($sformatf("tbl%0d", i), tbl[i]);

    // Back-to-back illegal opcodes: one pulse per handshake, ready never drops.
    valid = 1'b1; op = 7'b1111111; rd = 5'd1; rs1 = 5'd1; rs2 = 5'd1;
    @(negedge clk);
    check_obs("ill1 E1", ob1, exp_obs(tbl[2], 1, 1), 1'b0, 1'b0);
    check_obs("ill1 E4", ob4, exp_obs(tbl[2], 4, 1), 1'b0, 1'b0);
    @(negedge clk);
    valid = 1'b0;
    check_obs("ill2 E1", ob1, exp_obs(tbl[2], 1, 1), 1'b0, 1'b0);
    check_obs("ill2 E4", ob4, exp_obs(tbl[2], 4, 1), 1'b0, 1'b0);
    @(negedge clk);
    check_idle("ill-done");

    // Reset pulse while both DUTs are in EXEC: instruction must vanish.
    valid = 1'b1; op = tbl[0].op; rd = tbl[0].rd; rs1 = tbl[0].rs1; rs2 = tbl[0].rs2;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    check_obs("pre-rst E4", ob4, exp_obs(tbl[0], 4, 2), 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 check_idle("rst-async");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check_idle($sformatf("rst-discard%0d", k));
      @(negedge clk);
    end
    run_instr("after-rst", tbl[0]);

    for (int i = 0; i < 40; i++) begin
      logic [6:0] o;
      if ($urandom_range(0, 3) == 0) o = 7'($urandom);
      else o = legal_ops[$urandom_range(0, 8)];
      run_instr($sformatf("rnd%0d", i),
                model_rec(o, 5'($urandom), 5'($urandom), 5'($urandom)));
    end

`ifdef ALU_SEQ_PERF_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    valid = 1'b1; op = tbl[0].op; rd = tbl[0].rd; rs1 = tbl[0].rs1; rs2 = tbl[0].rs2;
    repeat (12) @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (perf_ret1 !== 32'd3) begin
      n_fail++;
      $display("FAIL perf_retired: got %0d want 3", perf_ret1);
    end
    n_tests++;
    if (perf_stall1 !== 32'd9) begin
      n_fail++;
      $display("FAIL perf_stall: got %0d want 9", perf_stall1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle execute controller placed between the decode stage and the opcode-routed ALU datapath. It accepts one decoded instruction per handshake and reads its source registers from the register file. It then drives the ALU opcode and operands for a fixed number of execute cycles, and retires the result with a register-file write-back strobe. It provides the only path by which the ALU datapath receives an opcode and operands.

## Interface
- EXEC_CYCLES, 1: cycles the ALU operands are held before the result is captured; must be ≥1 (elaboration error otherwise)
- XLEN, 32: datapath width

- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- iVALID  in  1  decoded instruction valid
- oREADY  out  1  sequencer can accept an instruction
- iOPCODE  in  7  RV32I major opcode
- iRD, iRS1, iRS2  in  5 each  decoded register indices
- oRF_RS1, oRF_RS2  out  5 each  register-file read addresses
- iRF_DATA1, iRF_DATA2  in  XLEN each  register-file read data, combinational from address
- oALU_OPCODE  out  7  opcode routed to the ALU datapath
- oALU_IN1, oALU_IN2  out  XLEN each  ALU operands
- iALU_OUT  in  XLEN  ALU result
- oWB_EN  out  1  register write strobe
- oWB_RD  out  5  write address
- oWB_DATA  out  XLEN  write data
- oRESULT_VALID  out  1  one-cycle pulse for every legal retired instruction
- oRESULT  out  XLEN  ALU result; consumed by the LSU for loads and stores and by the branch unit for branches
- oILLEGAL  out  1  one-cycle pulse when the opcode is unsupported
- oBUSY  out  1  state ≠ IDLE

## Operation
- FSM: IDLE → READ → EXEC → WB → IDLE.
  - **IDLE**: oREADY=1. On iVALID&&oREADY, latch the opcode, rd, rs1 and rs2.
    - A legal opcode goes to READ.
    - An illegal opcode pulses oILLEGAL for one cycle and stays in IDLE.
  - **READ**: drive oRF_RS1 and oRF_RS2 from the latched indices.
    - At the end of the cycle, capture iRF_DATA1 and iRF_DATA2 into the operand registers.
    - Indices are forced to 0 for U/J opcodes (0110111, 0010111, 1101111).
  - **EXEC**: hold oALU_OPCODE, oALU_IN1 and oALU_IN2 stable. Count down from EXEC_CYCLES; at the last cycle, capture iALU_OUT.
  - **WB**: for one cycle, assert oRESULT_VALID and oRESULT.
    - oWB_EN=1 only if the opcode class writes rd (0110011, 0010011, 1100111, 0110111, 0010111, 1101111) and rd≠0.
    - Loads (0000011), stores (0100011) and branches (1100011) retire with oWB_EN=0.
- Legal opcode set: the nine opcodes above. Anything else is illegal.
- oALU_OPCODE=0 and operands=0 outside EXEC, so the datapath sees no stale routing.
- The counter is $clog2(EXEC_CYCLES+1) bits wide and reloads on READ→EXEC.

## Timing
- Handshake in cycle N. READ is cycle N+1. EXEC spans cycles N+2 … N+1+EXEC_CYCLES. WB is cycle N+2+EXEC_CYCLES. The next accept is possible in cycle N+3+EXEC_CYCLES.
- Throughput is one instruction per EXEC_CYCLES+3 cycles.
- iVALID while oREADY=0 is ignored. Upstream holds the instruction until the handshake.
- All outputs are registered; nothing is combinational from iVALID except oREADY, which is a state decode.
- Reset values: state=IDLE, oREADY=1; every other output 0, including the counter.
- RST asserted mid-instruction: return to IDLE immediately and discard the instruction. No oWB_EN and no oRESULT_VALID are issued for it.
- Illegal opcode: oILLEGAL is high in cycle N+1 and oREADY stays 1, so back-to-back illegal opcodes pulse on consecutive cycles.
- rd=0 write-class instruction: oRESULT_VALID=1, oWB_EN=0.

## Configuration
- ALU_SEQ_PERF_EN defined: adds outputs oPERF_RETIRED (32) and oPERF_STALL (32).
  - oPERF_RETIRED increments on each oRESULT_VALID.
  - oPERF_STALL increments each cycle with iVALID=1 and oREADY=0.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- alu_seq_pkg holds:
  - opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR, OP_LUI, OP_AUIPC, OP_JAL)
  - the FSM state enum
  - functions is_legal(opcode), writes_rd(opcode) and uses_rs(opcode)
- One sub-module, alu_seq_classify: a combinational opcode → {legal, writes_rd, uses_rs} decoder, shared with the hazard logic.

## Test plan
- EXEC_CYCLES=1; opcode 0110011, rd=5, rs1=1, rs2=2, RF returns 3 and 4, iALU_OUT=7 → operands 3/4 during EXEC; in cycle N+3, oWB_EN=1, oWB_RD=5, oWB_DATA=7; oREADY=1 in cycle N+4.
- Store 0100011 with iALU_OUT=0x100 → oRESULT_VALID=1, oRESULT=0x100, oWB_EN=0.
- Opcode 1111111 → oILLEGAL high for 1 cycle at N+1, no READ state, oREADY stays 1.
- EXEC_CYCLES=4; LUI with rd=0 → oRF_RS1=oRF_RS2=0, EXEC lasts 4 cycles, oRESULT_VALID at N+6, oWB_EN=0.
- RST pulsed during EXEC → oBUSY=0 immediately, no WB pulse, next instruction is accepted normally.
- ALU_SEQ_PERF_EN defined: iVALID held high for 3 back-to-back instructions with EXEC_CYCLES=1 → oPERF_RETIRED=3, oPERF_STALL=9.
